// File: rtl/tone_sequencer_if.sv
// Codec write-FIFO port for tone_sequencer: sample strobe, stereo data and ready.
interface tone_sequencer_if;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;

    // Sequencer side drives samples, codec side reports FIFO space.
    modport master (
        input  write_ready,
        output write,
        output writedata_left,
        output writedata_right
    );

    modport slave (
        output write_ready,
        input  write,
        input  writedata_left,
        input  writedata_right
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a programmable note table and paces square-wave
// samples into the audio codec write FIFO.
// Optional feature: define TONE_SEQ_GAP_EN to insert GAP_MS silent ticks after each note.
module tone_sequencer #(
    parameter int unsigned NUM_NOTES = 8,
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [23:0] AMPLITUDE = 24'h000100,
    parameter int unsigned GAP_MS    = 10,
    localparam int unsigned IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            loop,
    input  logic            prog_we,
    input  logic [IW-1:0]   prog_addr,
    input  logic [19:0]     prog_half_period,
    input  logic [11:0]     prog_duration,
    tone_sequencer_if.master codec,
    output logic            busy,
    output logic [IW-1:0]   note_index,
    output logic            done
);

`ifdef TONE_SEQ_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LastIdx  = IW'(NUM_NOTES - 1);
    localparam logic [23:0]   AmpNeg   = ~AMPLITUDE + 24'd1;
    localparam logic [11:0]   GapTicks = 12'(GAP_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    // Note table storage, kept across reset.
    logic [19:0] hp_mem  [NUM_NOTES];
    logic [11:0] dur_mem [NUM_NOTES];

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic [11:0]     dur_q, dur_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [19:0]     half_q, half_d;
    logic [19:0]     hp_q, hp_d;
    logic            phase_q, phase_d;
    logic [11:0]     gap_q, gap_d;
    logic            write_q, write_d;
    logic [23:0]     wdata_q;
    logic            busy_q;
    logic            done_q;

    logic            tick_c;
    logic            expire_c;
    logic [23:0]     sample_c;

    // Table programming port; usable at any time.
    always_ff @(posedge CLOCK_50) begin
        if (prog_we) begin
            hp_mem[prog_addr]  <= prog_half_period;
            dur_mem[prog_addr] <= prog_duration;
        end
    end

    // Current sample: square level while playing, silence for rests and gaps.
    always_comb begin
        sample_c = 24'd0;
        if (state_q == S_PLAY && hp_q != 20'd0) begin
            sample_c = phase_q ? AmpNeg : AMPLITUDE;
        end
    end

    // Next-state logic for the sequencer, counters and write pacing.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        dur_d    = dur_q;
        presc_d  = presc_q;
        half_d   = half_q;
        hp_d     = hp_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        expire_c = 1'b0;
        tick_c   = (presc_q == PrescMax);

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    index_d = '0;
                end
            end
            S_LOAD: begin
                if (dur_mem[index_q] == 12'd0) begin
                    state_d = S_DONE;
                end else begin
                    dur_d   = dur_mem[index_q];
                    hp_d    = hp_mem[index_q];
                    presc_d = '0;
                    half_d  = 20'd0;
                    phase_d = 1'b0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                presc_d = tick_c ? '0 : presc_q + PW'(1);
                if (hp_q != 20'd0) begin
                    if (half_q == hp_q - 20'd1) begin
                        half_d  = 20'd0;
                        phase_d = ~phase_q;
                    end else begin
                        half_d = half_q + 20'd1;
                    end
                end
                if (tick_c) begin
                    dur_d = dur_q - 12'd1;
                    if (dur_q == 12'd1) begin
                        if (GapEn && GapTicks != 12'd0) begin
                            state_d = S_GAP;
                            presc_d = '0;
                            gap_d   = GapTicks;
                        end else begin
                            expire_c = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                presc_d = tick_c ? '0 : presc_q + PW'(1);
                if (tick_c) begin
                    gap_d = gap_q - 12'd1;
                    if (gap_q == 12'd1) begin
                        expire_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                index_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Next-note decision after a note (and its gap) has finished.
        if (expire_c) begin
            if (index_q < LastIdx) begin
                index_d = index_q + IW'(1);
                state_d = S_LOAD;
            end else if (loop) begin
                index_d = '0;
                state_d = S_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end

        // Stop aborts from any active state without a done pulse.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            index_d = '0;
        end

        write_d = (state_q == S_PLAY || state_q == S_GAP) && codec.write_ready
                  && !write_q && !stop;
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            dur_q   <= 12'd0;
            presc_q <= '0;
            half_q  <= 20'd0;
            hp_q    <= 20'd0;
            phase_q <= 1'b0;
            gap_q   <= 12'd0;
            write_q <= 1'b0;
            wdata_q <= 24'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            half_q  <= half_d;
            hp_q    <= hp_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            write_q <= write_d;
            if (write_d) begin
                wdata_q <= sample_c;
            end
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign codec.write           = write_q;
    assign codec.writedata_left  = wdata_q;
    assign codec.writedata_right = wdata_q;
    assign busy                  = busy_q;
    assign note_index            = index_q;
    assign done                  = done_q;

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a programmable melody through the audio codec by sequencing a runtime-configurable square-wave datapath. Holds a small note table (half-period, duration), steps through it under a start/stop/loop control FSM, and paces 24-bit samples into the codec write FIFO using its write_ready/write handshake. It sits between the control logic (switches/keys or CPU) and the audio codec core, replacing fixed-frequency tone generation.

## Interface
- NUM_NOTES, 8: note table depth; index width IW = $clog2(NUM_NOTES)
- TICK_DIV, 50000: CLOCK_50 cycles per duration tick (1 ms at 50 MHz)
- AMPLITUDE, 24'h000100: positive square level; negative level is two's-complement -AMPLITUDE
- GAP_MS, 10: silent ticks between notes (used only with TONE_SEQ_GAP_EN)

- CLOCK_50  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- start  in  1  begin playback from note 0 (IDLE only)
- stop  in  1  abort playback; wins over start
- loop  in  1  sampled at end of last note: 1 = restart at note 0
- prog_we  in  1  note table write strobe
- prog_addr  in  IW  table index
- prog_half_period  in  20  CLOCK_50 cycles per half wave; 0 = rest
- prog_duration  in  12  note length in ticks; 0 = end-of-sequence marker
- write_ready  in  1  codec FIFO has space
- write  out  1  one-cycle sample write strobe
- writedata_left  out  24  sample, left
- writedata_right  out  24  sample, right (identical to left)
- busy  out  1  state not IDLE
- note_index  out  IW  current table index
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start & !stop -> LOAD with index 0. start while busy ignored.
- LOAD (1 cycle): read table[index]; duration 0 -> DONE; else load duration counter, clear tick prescaler, clear half-period counter, phase = +AMPLITUDE -> PLAY.
- PLAY: prescaler counts 0..TICK_DIV-1; each wrap decrements duration; duration expiring -> GAP (macro) or next-note decision.
- Next-note: index < NUM_NOTES-1 -> index+1, LOAD; last index: loop=1 -> index 0, LOAD; loop=0 -> DONE.
- DONE (1 cycle): done=1 -> IDLE, index to 0.
- stop in any non-IDLE state -> IDLE next cycle; write deasserts that cycle; no done pulse.
- Waveform: half counter 0..half_period-1; at half_period-1 phase negates, counter to 0. half_period 0 -> sample 0 (rest).
- Sample = phase in PLAY, 0 in GAP; writedata updated only with a write.
- Write pacing: write = 1 when state in {PLAY, GAP}, write_ready=1, and write was 0 the previous cycle (max one write every two cycles, absorbs ready latency).
- Table writes allowed any time; write to the playing index takes effect at next LOAD.

## Timing
- Reset values: write 0, writedata_left/right 0, busy 0, note_index 0, done 0, state IDLE, phase +AMPLITUDE.
- start to LOAD: 1 cycle; LOAD to PLAY: 1 cycle; busy high from LOAD.
- PLAY lasts exactly duration x TICK_DIV cycles.
- First toggle: half_period cycles after PLAY entry.
- write and writedata registered together; data valid in the write cycle.
- reset mid-operation: all outputs return to reset values on the next edge; table contents retained.

## Configuration
- TONE_SEQ_GAP_EN defined: after each note, GAP state for GAP_MS ticks emitting 0 samples, then next-note decision; stop aborts GAP too.
- Undefined: no GAP state; PLAY expiry goes directly to next-note decision; GAP_MS unused.

## Test plan
- TICK_DIV=10; note0 half=4 dur=2, note1 dur=0; start, write_ready=1 -> PLAY 20 cycles, samples 0x000100 / 0xFFFF00 alternating every 4 cycles, write every other cycle, done pulse, busy 0.
- note0 half=0 dur=1 -> 10 PLAY cycles, all written samples 0x000000.
- Two notes, loop=1 -> note_index 0,1,0,1; stop mid-PLAY -> IDLE next cycle, write 0, no done.
- write_ready low throughout PLAY -> no writes; raised -> writes resume at every second cycle.
- reset during PLAY -> all outputs reset next cycle; start and stop same cycle in IDLE -> stays IDLE.
- TONE_SEQ_GAP_EN, GAP_MS=1 -> 10 cycles of zero-data writes between note0 and note1.
